// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input valid/ready stream selector, fixed-select or round-robin, registered output.
module stream_mux_rr #(
  parameter int WIDTH = 2,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_src
);
  localparam int VW = 2**SEL_W;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_src_q, out_src_d, ptr_q, ptr_d, rr_g, cand, g;
  logic [VW-1:0]    valid_pad;
  logic             load, rr_hit, grant;
  // Zero-padded valid lets an out-of-range sel read as "not valid".
  always_comb begin
    valid_pad = VW'(in_valid);
    load = !out_valid_q || out_ready;
    rr_g = ptr_q;
    rr_hit = 1'b0;
    cand = '0;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      cand = SEL_W'((int'(ptr_q) + k) % NUM_IN);
      if (valid_pad[cand]) begin
        rr_g = cand;
        rr_hit = 1'b1;
      end
    end
    g = mode ? rr_g : sel;
    grant = !rst && load && (mode ? rr_hit : valid_pad[sel]);
    in_ready = grant ? NUM_IN'(1) << g : '0;
    out_valid_d = grant || (out_valid_q && !out_ready);
    out_data_d = grant ? in_data[32'(g)*WIDTH +: WIDTH] : out_data_q;
    out_src_d = grant ? g : out_src_q;
    ptr_d = (grant && mode) ? ((int'(g) == NUM_IN-1) ? '0 : g + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src = out_src_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: vector table, NUM_IN=3 corner sequence and randomized model check.
module tb_stream_mux_rr;
  logic       clk = 1'b0;
  logic       rst, mode, out_ready, out_valid;
  logic [1:0] sel, out_data, out_src;
  logic [7:0] in_data;
  logic [3:0] in_valid, in_ready;
  logic       rst3, mode3, out_ready3, out_valid3;
  logic [1:0] sel3, out_data3, out_src3;
  logic [5:0] in_data3;
  logic [2:0] in_valid3, in_ready3;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  stream_mux_rr #(.WIDTH(2), .NUM_IN(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src));
  stream_mux_rr #(.WIDTH(2), .NUM_IN(3)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_src(out_src3));
  typedef struct packed {
    logic r; logic md; logic [1:0] s; logic [3:0] v; logic o;
    logic [3:0] ir; logic ov; logic [1:0] od; logic [1:0] os;
  } vec_t;
  vec_t tbl [26];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic apply(input logic r, input logic md, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] v, input logic o);
    @(negedge clk);
    rst = r; mode = md; sel = s; in_data = d; in_valid = v; out_ready = o;
    #1;
  endtask
  task automatic step3(input logic r, input logic [1:0] s, input int ir, input int ov,
                       input int od, input int os, input string nm);
    @(negedge clk);
    rst3 = r; sel3 = s;
    #1;
    chk({nm, " in_ready"}, in_ready3, ir);
    @(posedge clk); #1;
    chk({nm, " out_valid"}, out_valid3, ov);
    chk({nm, " out_data"}, out_data3, od);
    chk({nm, " out_src"}, out_src3, os);
  endtask
  initial begin
    int m_ptr, m_v, m_d, m_s, g, e_ir;
    rst = 1; mode = 0; sel = 0; in_data = 0; in_valid = 0; out_ready = 1;
    rst3 = 1; mode3 = 0; sel3 = 0; in_data3 = 6'b10_01_11; in_valid3 = 3'b111; out_ready3 = 1;
    // r md s v o | ir ov od os ; data fixed at ch3..ch0 = 10,01,00,11
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 2'd1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 2'd2};
    tbl[4]  = '{1'b0, 1'b0, 2'd3, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 2'd3};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 2'd2};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 2'd3};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 2'd1};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[12] = '{1'b0, 1'b1, 2'd0, 4'h5, 1'b1, 4'h4, 1'b1, 2'd1, 2'd2};
    tbl[13] = '{1'b0, 1'b1, 2'd0, 4'h5, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[14] = '{1'b0, 1'b1, 2'd0, 4'h5, 1'b1, 4'h4, 1'b1, 2'd1, 2'd2};
    tbl[15] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 2'd2};
    tbl[16] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 2'd2};
    tbl[17] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 2'd2};
    tbl[18] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 2'd3};
    tbl[19] = '{1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[20] = '{1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0};
    tbl[21] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 2'd0};
    tbl[22] = '{1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd3, 2'd0};
    tbl[23] = '{1'b0, 1'b0, 2'd1, 4'hD, 1'b1, 4'h0, 1'b0, 2'd3, 2'd0};
    tbl[24] = '{1'b0, 1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 2'd2};
    tbl[25] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 2'd1};
    for (int i = 0; i < 26; i++) begin
      apply(tbl[i].r, tbl[i].md, tbl[i].s, 8'h93, tbl[i].v, tbl[i].o);
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].ir);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d out_src", i), out_src, tbl[i].os);
    end
    // Three-input instance: out-of-range sel drains the held word, then resumes.
    step3(1'b1, 2'd0, 0, 0, 0, 0, "n3 reset");
    step3(1'b0, 2'd0, 1, 1, 3, 0, "n3 sel0");
    step3(1'b0, 2'd3, 0, 0, 3, 0, "n3 sel3 drain");
    step3(1'b0, 2'd3, 0, 0, 3, 0, "n3 sel3 idle");
    step3(1'b0, 2'd2, 4, 1, 2, 2, "n3 sel2");
    // Randomized run against a queue-free behavioural model.
    apply(1'b1, 1'b0, 2'd0, 8'h00, 4'h0, 1'b1);
    @(posedge clk); #1;
    m_ptr = 0; m_v = 0; m_d = 0; m_s = 0;
    for (int c = 0; c < 600; c++) begin
      apply(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), ($urandom_range(0, 3) != 0));
      g = -1;
      if (mode == 1'b0) begin
        if (in_valid[sel]) g = int'(sel);
      end else begin
        for (int k = 3; k >= 0; k--)
          if (in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if (rst || (m_v == 1 && !out_ready)) g = -1;
      e_ir = (g >= 0) ? (1 << g) : 0;
      chk($sformatf("rnd%0d in_ready", c), in_ready, e_ir);
      if (rst) begin
        m_ptr = 0; m_v = 0; m_d = 0; m_s = 0;
      end else if (g >= 0) begin
        m_v = 1; m_d = (int'(in_data) >> (2 * g)) & 3; m_s = g;
        if (mode) m_ptr = (g + 1) % 4;
      end else if (out_ready) m_v = 0;
      @(posedge clk); #1;
      chk($sformatf("rnd%0d out_valid", c), out_valid, m_v);
      chk($sformatf("rnd%0d out_data", c), out_data, m_d);
      chk($sformatf("rnd%0d out_src", c), out_src, m_s);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
